ha_burst_accumulator: RTL and testbench
=======================================

// Module: ha_burst_accumulator
// PURPOSE
//  Downstream consumer of the half-adder stage. Takes per-cycle {carry,sum} result pairs
//  via a valid/ready handshake and accumulates their numeric weight (2*carry + sum) over
//  a fixed burst of BURST_LEN samples. It then presents the burst total, with sticky
//  overflow and illegal-code flags, on a held valid/ready output.
//  Sits between the half-adder cell and the uo_out display/readout logic.
// PARAMETERS
//  ACC_W      8   accumulator/total width in bits; arithmetic is modulo 2**ACC_W
//  BURST_LEN  4   accepted samples per burst; legal range 1..255
// PORTS
//  clk        in   1      single clock domain; all state updates on rising edge
//  rst        in   1      reset, asynchronous, active-high
//  clear      in   1      synchronous abort: drop partial burst and pending result
//  in_valid   in   1      upstream sample present
//  in_sum     in   1      half-adder sum bit
//  in_carry   in   1      half-adder carry bit
//  in_ready   out  1      block accepts a sample this cycle
//  out_valid  out  1      burst result available
//  out_ready  in   1      downstream accepts the result
//  out_total  out  ACC_W  burst total, modulo 2**ACC_W
//  out_ovf    out  1      sticky: the total wrapped past 2**ACC_W-1 during this burst
//  out_err    out  1      sticky: illegal code {carry,sum}=2'b11 was seen during this burst
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high.
//  - Reset values: state=IDLE, acc=0, cnt=0, out_valid=0, out_total=0, out_ovf=0, out_err=0.
//  - While rst=1, in_ready=0. Reset mid-burst or mid-HOLD discards everything; no partial result is emitted.
//  - Accept = in_valid & in_ready. in_ready = (state!=HOLD) & !rst & !clear (combinational).
//  - Weight w = {in_carry,in_sum} as a 2-bit unsigned value, so 0..3.
//    * 2'b11 is accumulated as 3 and sets err.
//    * The sum is zero-extended to ACC_W+1 bits; bit ACC_W of the sum ORs into ovf.
//  - FSM:
//    * IDLE:  on accept, acc<=w, cnt<=1, ovf/err are set from this sample, go to ACCUM.
//             If BURST_LEN==1, go directly to HOLD instead.
//    * ACCUM: on accept, acc<=acc+w, cnt<=cnt+1.
//             When this accept is the BURST_LEN-th sample, go to HOLD.
//             Idle cycles (no accept) leave all state unchanged.
//    * HOLD:  on entry, out_total/out_ovf/out_err are registered and out_valid=1.
//             Latency: out_valid rises the cycle after the last sample is accepted.
//             Outputs are stable while out_valid & !out_ready.
//             On out_valid & out_ready: out_valid<=0, acc/cnt/flags<=0, go to IDLE.
//             A sample presented in that same cycle is NOT accepted (in_ready=0). It is accepted
//             next cycle at the earliest, so there is one bubble per burst.
//  - out_total/out_ovf/out_err hold their last values after the handshake completes, until the next HOLD entry.
//  - clear=1 (sync) has priority over accept and handshake:
//    * next state=IDLE; acc, cnt, ovf, err and out_valid go to 0.
//    * Any sample offered that cycle is dropped.
//  - cnt width = clog2(BURST_LEN+1). cnt never exceeds BURST_LEN.
// TESTING
//  1. Default params; samples (c,s)=(0,1),(1,0),(0,1),(0,0), back-to-back, out_ready=1
//     -> out_valid one cycle after the 4th accept; out_total=4, ovf=0, err=0; in_ready=0 that cycle.
//  2. Hold out_ready=0 for 5 cycles in HOLD
//     -> out_valid, out_total and flags stable; in_ready=0; in_valid pulses ignored (not counted later).
//  3. ACC_W=3, BURST_LEN=4; four samples (1,0)
//     -> out_total=0 (8 mod 8), out_ovf=1.
//  4. Sample (1,1) followed by three (0,0)
//     -> out_total=3, out_err=1; the next burst of zeros reports out_err=0.
//  5. Assert clear in the same cycle as the 4th sample
//     -> no out_valid; next 4 samples of (0,1) -> out_total=4 (not 5 or more).
//  6. Assert rst asynchronously between clock edges mid-ACCUM and mid-HOLD
//     -> outputs go to reset values immediately; in_ready=0 until rst is released.

Source files
------------

// File: rtl/ha_burst_accumulator.sv
// ha_burst_accumulator: sums half-adder {carry,sum} weights over a fixed burst
// of BURST_LEN accepted samples and presents the total with sticky overflow and
// illegal-code flags on a held valid/ready output.
module ha_burst_accumulator #(
   parameter int ACC_W     = 8,
   parameter int BURST_LEN = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             in_valid,
   input  logic             in_sum,
   input  logic             in_carry,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_total,
   output logic             out_ovf,
   output logic             out_err
);

   localparam int CNT_W = $clog2(BURST_LEN + 1);

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   state_t             state, state_nxt;
   logic [ACC_W-1:0]   acc;
   logic [CNT_W-1:0]   cnt;
   logic               ovf, err;

   logic               accept, last, handshake;
   logic [1:0]         w;
   logic [ACC_W-1:0]   base;
   logic [ACC_W:0]     sum;
   logic [CNT_W-1:0]   cnt_inc;
   logic               ovf_nxt, err_nxt;

   assign in_ready  = (state != HOLD) & ~rst & ~clear;
   assign accept    = in_valid & in_ready;
   assign handshake = (state == HOLD) & out_valid & out_ready;

   // Candidate accumulator/count/flag values for an accepted sample; IDLE starts a fresh burst
   always_comb begin
      w       = {in_carry, in_sum};
      base    = (state == IDLE) ? '0 : acc;
      sum     = {1'b0, base} + (ACC_W + 1)'(w);
      cnt_inc = (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
      ovf_nxt = ((state != IDLE) & ovf) | sum[ACC_W];
      err_nxt = ((state != IDLE) & err) | (w == 2'b11);
      last    = (cnt_inc == CNT_W'(BURST_LEN));
   end

   // Next-state logic: clear overrides both accept and result handshake
   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE, ACCUM: if (accept) state_nxt = last ? HOLD : ACCUM;
            HOLD:        if (handshake) state_nxt = IDLE;
            default:     state_nxt = IDLE;
         endcase
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Accumulation datapath and result registers; results latch on HOLD entry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         err       <= 1'b0;
         out_valid <= 1'b0;
         out_total <= '0;
         out_ovf   <= 1'b0;
         out_err   <= 1'b0;
      end else if (clear) begin
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         err       <= 1'b0;
         out_valid <= 1'b0;
      end else if (accept) begin
         acc <= sum[ACC_W-1:0];
         cnt <= cnt_inc;
         ovf <= ovf_nxt;
         err <= err_nxt;
         if (last) begin
            out_total <= sum[ACC_W-1:0];
            out_ovf   <= ovf_nxt;
            out_err   <= err_nxt;
            out_valid <= 1'b1;
         end
      end else if (handshake) begin
         acc       <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         err       <= 1'b0;
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ha_burst_accumulator.sv
// Bench for ha_burst_accumulator: two instances (8-bit and 3-bit accumulator)
// driven by shared stimulus and checked against a queue-based burst model.
module tb_ha_burst_accumulator;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, clear, in_valid, in_sum, in_carry, out_ready;
   logic       rdy_a, vld_a, ovf_a, err_a;
   logic [7:0] tot_a;
   logic       rdy_b, vld_b, ovf_b, err_b;
   logic [2:0] tot_b;

   ha_burst_accumulator #(.ACC_W(8), .BURST_LEN(4)) dut_a (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_sum(in_sum),
      .in_carry(in_carry), .in_ready(rdy_a), .out_valid(vld_a), .out_ready(out_ready),
      .out_total(tot_a), .out_ovf(ovf_a), .out_err(err_a));

   ha_burst_accumulator #(.ACC_W(3), .BURST_LEN(4)) dut_b (
      .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_sum(in_sum),
      .in_carry(in_carry), .in_ready(rdy_b), .out_valid(vld_b), .out_ready(out_ready),
      .out_total(tot_b), .out_ovf(ovf_b), .out_err(err_b));

   int tests = 0;
   int fails = 0;

   // Reference model: the weights accepted in the current burst
   int q[$];
   bit m_hold = 0;
   int e_tot_a = 0, e_tot_b = 0;
   bit e_ovf_a = 0, e_ovf_b = 0, e_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic publish();
      int raw = 0;
      e_err = 0;
      foreach (q[i]) begin
         raw += q[i];
         if (q[i] == 3) e_err = 1;
      end
      e_tot_a = raw % 256;
      e_ovf_a = (raw >= 256);
      e_tot_b = raw % 8;
      e_ovf_b = (raw >= 8);
   endtask

   task automatic chk_outputs();
      chk("out_valid_a", vld_a, m_hold);
      chk("out_valid_b", vld_b, m_hold);
      chk("out_total_a", tot_a, e_tot_a);
      chk("out_total_b", tot_b, e_tot_b);
      chk("out_ovf_a", ovf_a, e_ovf_a);
      chk("out_ovf_b", ovf_b, e_ovf_b);
      chk("out_err_a", err_a, e_err);
      chk("out_err_b", err_b, e_err);
   endtask

   // One clock cycle of stimulus; entered and left at the falling edge
   task automatic step(input bit v, input bit c, input bit s, input bit ordy, input bit clr);
      in_valid  = v;
      in_carry  = c;
      in_sum    = s;
      out_ready = ordy;
      clear     = clr;
      #1;
      chk("in_ready_a", rdy_a, !m_hold && !clr);
      chk("in_ready_b", rdy_b, !m_hold && !clr);
      @(posedge clk);
      if (clr) begin
         q.delete();
         m_hold = 0;
      end else if (m_hold) begin
         if (ordy) begin
            m_hold = 0;
            q.delete();
         end
      end else if (v) begin
         q.push_back(int'({c, s}));
         if (q.size() == 4) begin
            m_hold = 1;
            publish();
         end
      end
      @(negedge clk);
      chk_outputs();
   endtask

   task automatic async_reset();
      in_valid = 1'b1;
      clear    = 1'b0;
      #2 rst = 1'b1;
      q.delete();
      m_hold  = 0;
      e_tot_a = 0; e_tot_b = 0;
      e_ovf_a = 0; e_ovf_b = 0; e_err = 0;
      #1;
      chk_outputs();
      chk("rst_in_ready_a", rdy_a, 1'b0);
      chk("rst_in_ready_b", rdy_b, 1'b0);
      @(posedge clk);
      @(negedge clk);
      chk("rst_hold_in_ready_a", rdy_a, 1'b0);
      chk_outputs();
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready_a", rdy_a, 1'b1);
      chk("post_rst_in_ready_b", rdy_b, 1'b1);
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_sum = 1'b0; in_carry = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk_outputs();
      chk("reset_in_ready_a", rdy_a, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Burst of weights 1,2,1,0 back-to-back, then handshake with a bubble sample offered
      step(1, 0, 1, 1, 0); step(1, 1, 0, 1, 0); step(1, 0, 1, 1, 0); step(1, 0, 0, 1, 0);
      step(1, 0, 1, 1, 0);

      // Result held for five cycles with in_valid pulses that must be ignored
      for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 0);
      for (int i = 0; i < 5; i++) step(i[0], 1, 1, 0, 0);
      step(0, 0, 0, 1, 0);

      // Four weight-2 samples: wraps the 3-bit instance
      for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 0);
      step(0, 0, 0, 1, 0);

      // Illegal code then zeros; next all-zero burst must clear the error flag
      step(1, 1, 1, 1, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);

      // Clear coincident with the 4th sample drops the burst
      for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 0);
      step(1, 0, 1, 1, 1);
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 0);
      step(0, 0, 0, 1, 0);

      // Asynchronous reset mid-accumulation and mid-hold
      step(1, 1, 0, 0, 0); step(1, 1, 1, 0, 0);
      async_reset();
      for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
      async_reset();
      for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 0);
      step(0, 0, 0, 1, 0);

      // Randomized traffic with stalls, backpressure and occasional clears
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
